// File: rtl/gshare_predictor.sv
// gshare_predictor
//   Gshare branch direction predictor with a direct-mapped BTB. IF uses it to select the next PC.
//   The counter table is indexed by PC XOR global history. The history is shifted
//   speculatively at prediction time and repaired from EX on a mispredict. After reset, a
//   sweep FSM initialises one counter and one BTB valid bit per cycle before the block
//   reports ready.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   ready_o                       init sweep finished; predictions/updates are honoured
//   pred_valid_i, pred_pc_i       IF prediction request (word address)
//   pred_taken_o, pred_target_o   combinational prediction; target is 0 unless taken
//   pred_ghr_o                    history used for this prediction, carried to EX
//   upd_valid_i, upd_pc_i,        EX resolution: branch address, history snapshot,
//   upd_ghr_i, upd_taken_i,       actual direction and target, mispredict flag
//   upd_target_i, upd_mispredict_i
//   perf_upd_o, perf_miss_o       update / mispredict event counters (GSHARE_PERF_CNT_EN only)
//
// Configuration
//   GSHARE_PERF_CNT_EN  when defined, adds the two 32-bit wrapping performance counters.
//
// Parameter assumptions: 1 <= GHR_SIZE <= IDX_BITS, COUNTER_TABLE_SZ >= 2 and
// 2 <= BTB_DEPTH <= COUNTER_TABLE_SZ (both powers of 2), ADDR_WIDTH > IDX_BITS.
module gshare_predictor #(
  parameter int unsigned GHR_SIZE         = 8,
  parameter int unsigned COUNTER_TABLE_SZ = 1024,
  parameter int unsigned COUNTER_BITS     = 2,
  parameter int unsigned ADDR_WIDTH       = 12,
  parameter int unsigned BTB_DEPTH        = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready_o,
  input  logic                  pred_valid_i,
  input  logic [ADDR_WIDTH-1:0] pred_pc_i,
  output logic                  pred_taken_o,
  output logic [31:0]           pred_target_o,
  output logic [GHR_SIZE-1:0]   pred_ghr_o,
  input  logic                  upd_valid_i,
  input  logic [ADDR_WIDTH-1:0] upd_pc_i,
  input  logic [GHR_SIZE-1:0]   upd_ghr_i,
  input  logic                  upd_taken_i,
  input  logic [31:0]           upd_target_i,
  input  logic                  upd_mispredict_i
`ifdef GSHARE_PERF_CNT_EN
  ,
  output logic [31:0]           perf_upd_o,
  output logic [31:0]           perf_miss_o
`endif
);

  localparam int unsigned IDX_BITS = $clog2(COUNTER_TABLE_SZ);
  localparam int unsigned BTB_IDX  = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_BITS = ADDR_WIDTH - BTB_IDX;

  // Weakly not-taken: MSB clear, all lower bits set.
  localparam logic [COUNTER_BITS-1:0] CntWeakNt = COUNTER_BITS'((2 ** (COUNTER_BITS - 1)) - 1);
  localparam logic [COUNTER_BITS-1:0] CntMax    = '1;
  localparam logic [IDX_BITS-1:0]     SweepLast = IDX_BITS'(COUNTER_TABLE_SZ - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [IDX_BITS-1:0] sweep_q, sweep_d;
  logic [GHR_SIZE-1:0] ghr_q, ghr_d;

  // Storage arrays are not reset; the init sweep clears them.
  logic [COUNTER_BITS-1:0] cnt_q        [COUNTER_TABLE_SZ];
  logic                    btb_valid_q  [BTB_DEPTH];
  logic [TAG_BITS-1:0]     btb_tag_q    [BTB_DEPTH];
  logic [31:0]             btb_target_q [BTB_DEPTH];

  logic run;
  assign run     = (state_q == StRun);
  assign ready_o = run;

  // ---------------------------------------------------------------------------------------------
  // Prediction read path (asynchronous table reads)
  // ---------------------------------------------------------------------------------------------
  logic [IDX_BITS-1:0]     pred_idx;
  logic [BTB_IDX-1:0]      pred_btb_idx;
  logic [TAG_BITS-1:0]     pred_tag;
  logic [COUNTER_BITS-1:0] pred_cnt;
  logic                    btb_hit;

  assign pred_idx     = pred_pc_i[IDX_BITS-1:0] ^ IDX_BITS'(ghr_q);
  assign pred_btb_idx = pred_pc_i[BTB_IDX-1:0];
  assign pred_tag     = pred_pc_i[ADDR_WIDTH-1:BTB_IDX];
  assign pred_cnt     = cnt_q[pred_idx];
  assign btb_hit      = btb_valid_q[pred_btb_idx] && (btb_tag_q[pred_btb_idx] == pred_tag);

  assign pred_taken_o  = run && btb_hit && pred_cnt[COUNTER_BITS-1];
  assign pred_target_o = pred_taken_o ? btb_target_q[pred_btb_idx] : '0;
  assign pred_ghr_o    = run ? ghr_q : '0;

  // ---------------------------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------------------------
  logic [IDX_BITS-1:0]     upd_idx;
  logic [BTB_IDX-1:0]      upd_btb_idx;
  logic [COUNTER_BITS-1:0] upd_cnt, upd_cnt_next;

  assign upd_idx     = upd_pc_i[IDX_BITS-1:0] ^ IDX_BITS'(upd_ghr_i);
  assign upd_btb_idx = upd_pc_i[BTB_IDX-1:0];
  assign upd_cnt     = cnt_q[upd_idx];

  always_comb begin
    upd_cnt_next = upd_cnt;
    if (upd_taken_i) begin
      if (upd_cnt != CntMax) upd_cnt_next = upd_cnt + COUNTER_BITS'(1);
    end else begin
      if (upd_cnt != '0) upd_cnt_next = upd_cnt - COUNTER_BITS'(1);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Global history: speculative shift and mispredict repair
  // ---------------------------------------------------------------------------------------------
  logic [GHR_SIZE-1:0] ghr_spec, ghr_repair;

  if (GHR_SIZE == 1) begin : g_ghr_single
    assign ghr_spec   = pred_taken_o;
    assign ghr_repair = upd_taken_i;
  end else begin : g_ghr_multi
    assign ghr_spec   = {ghr_q[GHR_SIZE-2:0], pred_taken_o};
    assign ghr_repair = {upd_ghr_i[GHR_SIZE-2:0], upd_taken_i};
  end

  always_comb begin
    ghr_d = ghr_q;
    if (run) begin
      // Repair wins over a same-cycle speculative shift.
      if (upd_valid_i && upd_mispredict_i) begin
        ghr_d = ghr_repair;
      end else if (pred_valid_i && btb_hit) begin
        ghr_d = ghr_spec;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Init sweep FSM
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      StInit: begin
        sweep_d = sweep_q + IDX_BITS'(1);
        if (sweep_q == SweepLast) state_d = StRun;
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      sweep_q <= '0;
      ghr_q   <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ghr_q   <= ghr_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Table writes
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) begin
        cnt_q[sweep_q] <= CntWeakNt;
      end else if (upd_valid_i) begin
        cnt_q[upd_idx] <= upd_cnt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) begin
        btb_valid_q[sweep_q[BTB_IDX-1:0]] <= 1'b0;
      end else if (upd_valid_i && upd_taken_i) begin
        btb_valid_q[upd_btb_idx]  <= 1'b1;
        btb_tag_q[upd_btb_idx]    <= upd_pc_i[ADDR_WIDTH-1:BTB_IDX];
        btb_target_q[upd_btb_idx] <= upd_target_i;
      end
    end
  end

`ifdef GSHARE_PERF_CNT_EN
  logic [31:0] perf_upd_q, perf_miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_upd_q  <= '0;
      perf_miss_q <= '0;
    end else if (run && upd_valid_i) begin
      perf_upd_q <= perf_upd_q + 32'd1;
      if (upd_mispredict_i) perf_miss_q <= perf_miss_q + 32'd1;
    end
  end

  assign perf_upd_o  = perf_upd_q;
  assign perf_miss_o = perf_miss_q;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor
//   Self-checking bench for gshare_predictor with default parameters. A behavioural model
//   (integer arrays, modulo arithmetic) tracks counters, BTB and history and supplies the
//   expected prediction outputs. GSHARE_PERF_CNT_EN enables the performance counter scenario.
module tb_gshare_predictor;

  localparam int GhrSize  = 8;
  localparam int TableSz  = 1024;
  localparam int CntBits  = 2;
  localparam int AddrW    = 12;
  localparam int BtbDepth = 64;
  localparam int CntMax   = (1 << CntBits) - 1;
  localparam int CntThr   = 1 << (CntBits - 1);
  localparam int CntInit  = CntThr - 1;
  localparam int GhrMod   = 1 << GhrSize;

  logic               clk = 1'b0;
  logic               rst;
  logic               ready;
  logic               pred_valid;
  logic [AddrW-1:0]   pred_pc;
  logic               pred_taken;
  logic [31:0]        pred_target;
  logic [GhrSize-1:0] pred_ghr;
  logic               upd_valid;
  logic [AddrW-1:0]   upd_pc;
  logic [GhrSize-1:0] upd_ghr;
  logic               upd_taken;
  logic [31:0]        upd_target;
  logic               upd_mispredict;
`ifdef GSHARE_PERF_CNT_EN
  logic [31:0]        perf_upd;
  logic [31:0]        perf_miss;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gshare_predictor #(
    .GHR_SIZE        (GhrSize),
    .COUNTER_TABLE_SZ(TableSz),
    .COUNTER_BITS    (CntBits),
    .ADDR_WIDTH      (AddrW),
    .BTB_DEPTH       (BtbDepth)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ready_o         (ready),
    .pred_valid_i    (pred_valid),
    .pred_pc_i       (pred_pc),
    .pred_taken_o    (pred_taken),
    .pred_target_o   (pred_target),
    .pred_ghr_o      (pred_ghr),
    .upd_valid_i     (upd_valid),
    .upd_pc_i        (upd_pc),
    .upd_ghr_i       (upd_ghr),
    .upd_taken_i     (upd_taken),
    .upd_target_i    (upd_target),
    .upd_mispredict_i(upd_mispredict)
`ifdef GSHARE_PERF_CNT_EN
    ,
    .perf_upd_o      (perf_upd),
    .perf_miss_o     (perf_miss)
`endif
  );

  // ---------------------------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------------------------
  int          m_cnt [TableSz];
  bit          m_bv  [BtbDepth];
  int          m_tag [BtbDepth];
  logic [31:0] m_tgt [BtbDepth];
  int          m_ghr;

  function automatic void m_reset();
    for (int i = 0; i < TableSz; i++) m_cnt[i] = CntInit;
    for (int i = 0; i < BtbDepth; i++) m_bv[i] = 1'b0;
    m_ghr = 0;
  endfunction

  function automatic bit m_hit(int pc);
    return m_bv[pc % BtbDepth] && (m_tag[pc % BtbDepth] == pc / BtbDepth);
  endfunction

  function automatic bit m_taken(int pc);
    return m_hit(pc) && (m_cnt[(pc % TableSz) ^ m_ghr] >= CntThr);
  endfunction

  function automatic logic [31:0] m_target(int pc);
    return m_taken(pc) ? m_tgt[pc % BtbDepth] : 32'd0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic m_commit();
    int ppc, upc, ughr, idx, b, ng;
    bit h, tk;
    ppc  = int'(pred_pc);
    upc  = int'(upd_pc);
    ughr = int'(upd_ghr);
    h    = m_hit(ppc);
    tk   = m_taken(ppc);
    ng   = m_ghr;
    if (upd_valid && upd_mispredict) ng = (ughr * 2 + int'(upd_taken)) % GhrMod;
    else if (pred_valid && h)        ng = (m_ghr * 2 + int'(tk)) % GhrMod;
    if (upd_valid) begin
      idx = (upc % TableSz) ^ ughr;
      if (upd_taken) begin
        if (m_cnt[idx] < CntMax) m_cnt[idx]++;
        b        = upc % BtbDepth;
        m_bv[b]  = 1'b1;
        m_tag[b] = upc / BtbDepth;
        m_tgt[b] = upd_target;
      end else if (m_cnt[idx] > 0) begin
        m_cnt[idx]--;
      end
    end
    m_ghr = ng;
  endtask

  // ---------------------------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    pred_valid = 0; pred_pc = '0; upd_valid = 0; upd_pc = '0; upd_ghr = '0;
    upd_taken = 0; upd_target = '0; upd_mispredict = 0;
  endtask

  task automatic set_rand();
    pred_valid     = 1'($urandom_range(0, 1));
    pred_pc        = AddrW'($urandom_range(0, 255));
    upd_valid      = 1'($urandom_range(0, 1));
    upd_pc         = AddrW'($urandom_range(0, 255));
    upd_ghr        = ($urandom_range(0, 1) == 1) ? GhrSize'(m_ghr) : GhrSize'($urandom);
    upd_taken      = 1'($urandom_range(0, 1));
    upd_target     = $urandom;
    upd_mispredict = ($urandom_range(0, 3) == 0);
  endtask

  task automatic drive(input int pv, input int ppc, input int uv, input int upc, input int ughr,
                       input int ut, input int utgt, input int umis);
    pred_valid = 1'(pv); pred_pc = AddrW'(ppc); upd_valid = 1'(uv); upd_pc = AddrW'(upc);
    upd_ghr = GhrSize'(ughr); upd_taken = 1'(ut); upd_target = 32'(utgt);
    upd_mispredict = 1'(umis);
  endtask

  // Runs the init sweep with random (ignored) traffic. n = cycles seen with ready low.
  task automatic run_sweep(output int n, output int leaks);
    n = 0;
    leaks = 0;
    while (n < 4000) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      if (pred_taken !== 1'b0 || pred_target !== 32'd0 || pred_ghr !== '0) leaks++;
      n++;
      set_rand();
    end
    set_idle();
    tick();
  endtask

  // ---------------------------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------------------------
  task automatic test_reset();
    int n, leaks;
    rst = 1; set_idle();
    tick(); tick();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready_in_rst got=%0b exp=0", ready); end
    rst = 0;
    run_sweep(n, leaks);
    m_reset();
    total++; if (n != 1024) begin bad++; $display("FAIL reset_init_cycles got=%0d exp=1024", n); end
    total++; if (leaks != 0) begin bad++; $display("FAIL reset_outputs_quiet got=%0d exp=0", leaks); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready_high got=%0b exp=1", ready); end
    total++; if (pred_ghr !== 8'h00) begin bad++; $display("FAIL reset_ghr got=%0h exp=0", pred_ghr); end
  endtask

  task automatic test_cold_miss();
    drive(1, 'h010, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL cold_taken got=%0b exp=0", pred_taken); end
    total++; if (pred_target !== 32'd0) begin bad++; $display("FAIL cold_target got=%0h exp=0", pred_target); end
    m_commit(); tick(); set_idle();
    total++; if (pred_ghr !== 8'h00) begin bad++; $display("FAIL cold_ghr got=%0h exp=0", pred_ghr); end
  endtask

  task automatic test_training();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 1, 'h010, 0, 1, 'h400, 0);
      m_commit(); tick();
    end
    drive(1, 'h010, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL train_taken got=%0b exp=1", pred_taken); end
    total++; if (pred_target !== 32'h400) begin bad++; $display("FAIL train_target got=%0h exp=400", pred_target); end
    total++; if (pred_ghr !== 8'h00) begin bad++; $display("FAIL train_ghr_before got=%0h exp=0", pred_ghr); end
    m_commit(); tick(); set_idle();
    total++; if (pred_ghr !== 8'h01) begin bad++; $display("FAIL train_ghr_after got=%0h exp=1", pred_ghr); end
  endtask

  task automatic test_saturation();
    drive(0, 0, 1, 'h200, 0, 0, 0, 1);   // repair history back to 0
    m_commit(); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 'h010, 0, 1, 'h400, 0);
      m_commit(); tick();
    end
    drive(0, 0, 1, 'h010, 0, 0, 0, 0);
    m_commit(); tick();
    drive(1, 'h010, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL sat_taken got=%0b exp=1", pred_taken); end
    total++; if (pred_target !== 32'h400) begin bad++; $display("FAIL sat_target got=%0h exp=400", pred_target); end
    m_commit(); tick();
    // Second not-taken (with repair to history 0) takes the counter 2 -> 1.
    drive(0, 0, 1, 'h010, 0, 0, 0, 1);
    m_commit(); tick();
    drive(1, 'h010, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL sat_weak_nt got=%0b exp=0", pred_taken); end
    total++; if (pred_target !== 32'd0) begin bad++; $display("FAIL sat_weak_target got=%0h exp=0", pred_target); end
    m_commit(); tick(); set_idle();
    total++; if (pred_ghr !== 8'h00) begin bad++; $display("FAIL sat_ghr_nt_shift got=%0h exp=0", pred_ghr); end
  endtask

  task automatic test_same_cycle();
    drive(1, 'h020, 1, 'h020, 0, 1, 'h777, 0);
    @(negedge clk);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL same_old_taken got=%0b exp=0", pred_taken); end
    m_commit(); tick();
    total++; if (pred_ghr !== 8'h00) begin bad++; $display("FAIL same_ghr got=%0h exp=0", pred_ghr); end
    drive(1, 'h020, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL same_new_taken got=%0b exp=1", pred_taken); end
    total++; if (pred_target !== 32'h777) begin bad++; $display("FAIL same_new_target got=%0h exp=777", pred_target); end
    m_commit(); tick(); set_idle();
  endtask

  task automatic test_repair();
    drive(0, 0, 1, 'h300, 'h52, 1, 'h123, 1);   // sets history to 0xA5
    m_commit(); tick();
    total++; if (pred_ghr !== 8'hA5) begin bad++; $display("FAIL repair_setup got=%0h exp=a5", pred_ghr); end
    drive(1, 'h010, 1, 'h050, 'h3C, 0, 0, 1);
    @(negedge clk);
    total++; if (pred_ghr !== 8'hA5) begin bad++; $display("FAIL repair_pred_ghr got=%0h exp=a5", pred_ghr); end
    m_commit(); tick(); set_idle();
    total++; if (pred_ghr !== 8'h78) begin bad++; $display("FAIL repair_ghr got=%0h exp=78", pred_ghr); end
  endtask

  task automatic test_random();
    logic [31:0] exp_tgt;
    bit          exp_tk;
    for (int i = 0; i < 600; i++) begin
      set_rand();
      @(negedge clk);
      exp_tk  = m_taken(int'(pred_pc));
      exp_tgt = m_target(int'(pred_pc));
      total++;
      if (pred_taken !== exp_tk) begin
        bad++; $display("FAIL rand_taken[%0d] got=%0b exp=%0b", i, pred_taken, exp_tk);
      end
      total++;
      if (pred_target !== exp_tgt) begin
        bad++; $display("FAIL rand_target[%0d] got=%0h exp=%0h", i, pred_target, exp_tgt);
      end
      total++;
      if (pred_ghr !== GhrSize'(m_ghr)) begin
        bad++; $display("FAIL rand_ghr[%0d] got=%0h exp=%0h", i, pred_ghr, m_ghr);
      end
      m_commit(); tick();
    end
    set_idle();
  endtask

  task automatic test_reset_mid_sweep();
    int n, leaks;
    rst = 1; set_idle(); tick();
    rst = 0;
    for (int i = 0; i < 500; i++) begin
      set_rand(); tick();
    end
    rst = 1; set_idle(); tick();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL mid_ready_in_rst got=%0b exp=0", ready); end
    rst = 0;
    run_sweep(n, leaks);
    m_reset();
    total++; if (n != 1024) begin bad++; $display("FAIL mid_init_cycles got=%0d exp=1024", n); end
    total++; if (leaks != 0) begin bad++; $display("FAIL mid_outputs_quiet got=%0d exp=0", leaks); end
    drive(1, 'h010, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL mid_btb_cleared got=%0b exp=0", pred_taken); end
    m_commit(); tick(); set_idle();
  endtask

`ifdef GSHARE_PERF_CNT_EN
  task automatic test_perf();
    int n, leaks;
    rst = 1; set_idle(); tick();
    rst = 0;
    run_sweep(n, leaks);
    m_reset();
    total++; if (perf_upd !== 32'd0) begin bad++; $display("FAIL perf_clear got=%0d exp=0", perf_upd); end
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
            $urandom, (i % 3 == 2) ? 1 : 0);
      m_commit(); tick();
      set_idle(); tick();
    end
    total++; if (perf_upd !== 32'd10) begin bad++; $display("FAIL perf_upd got=%0d exp=10", perf_upd); end
    total++; if (perf_miss !== 32'd3) begin bad++; $display("FAIL perf_miss got=%0d exp=3", perf_miss); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1;
    set_idle();
    test_reset();
    test_cold_miss();
    test_training();
    test_saturation();
    test_same_cycle();
    test_repair();
    test_random();
    test_reset_mid_sweep();
`ifdef GSHARE_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
